// File: rtl/mul_pipe_param.sv
// Two-stage pipelined multiplier with a valid/ready handshake on both sides.
// Stage 1 recodes y into radix-4 Booth digits over operands extended by two
// bits and reduces the partial products to a sum row and a carry row.
// Stage 2 adds those two rows into the result register.
`timescale 1ns/1ps
module mul_pipe_param #(
  parameter int WIDTH = 32
) (
  input  logic               mul_clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned EW  = WIDTH + 2;  // extended operand width
  localparam int unsigned PW  = 2 * WIDTH;  // product width
  localparam int unsigned NPP = EW / 2;     // number of Booth digits

  logic          s1_v_q;
  logic          s2_v_q;
  logic          s1_adv;
  logic          s2_adv;
  logic          accept;
  logic [PW-1:0] pp [NPP];
  logic [PW-1:0] corr;
  logic [PW-1:0] s1_sum_d;
  logic [PW-1:0] s1_carry_d;
  logic [PW-1:0] s1_sum_q;
  logic [PW-1:0] s1_carry_q;
  logic [PW-1:0] result_d;
  logic [PW-1:0] result_q;

  // Handshake: a stage takes new data when it is empty or its successor moves on.
  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    in_ready = s1_adv || !resetn;
    accept   = in_valid && s1_adv && !flush;
  end

  // Booth recoding: one partial product per digit of y; the +1 of each negated
  // digit is collected into a separate correction row instead of an adder.
  always_comb begin
    logic [EW-1:0] xe;
    logic [EW-1:0] ye;
    logic [EW:0]   yb;
    logic [PW-1:0] xw;
    logic [PW-1:0] mag;
    logic          b0;
    logic          b1;
    logic          b2;
    logic          one;
    logic          two;
    xe   = {{2{is_signed & x[WIDTH-1]}}, x};
    ye   = {{2{is_signed & y[WIDTH-1]}}, y};
    yb   = {ye, 1'b0};
    xw   = {{(PW-EW){xe[EW-1]}}, xe};
    corr = '0;
    mag  = '0;
    b0   = 1'b0;
    b1   = 1'b0;
    b2   = 1'b0;
    one  = 1'b0;
    two  = 1'b0;
    for (int unsigned i = 0; i < NPP; i++) begin
      b0  = yb[2*i];
      b1  = yb[2*i+1];
      b2  = yb[2*i+2];
      one = b1 ^ b0;
      two = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
      mag = one ? xw : (two ? (xw << 1) : '0);
      // -(m << k) == (~m << k) + (1 << k) modulo 2^PW
      pp[i]       = (b2 ? ~mag : mag) << (2*i);
      corr[2*i]   = b2;
    end
  end

  // Carry-save reduction of all partial products and the correction row to two rows.
  always_comb begin
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] t;
    s = pp[0];
    c = pp[1];
    t = '0;
    for (int unsigned i = 2; i < NPP; i++) begin
      t = s ^ c ^ pp[i];
      c = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
      s = t;
    end
    t          = s ^ c ^ corr;
    c          = ((s & c) | (s & corr) | (c & corr)) << 1;
    s          = t;
    s1_sum_d   = s;
    s1_carry_d = c;
  end

  // Final carry-propagate addition feeding the result register.
  always_comb begin
    result_d = s1_sum_q + s1_carry_q;
  end

  // Stage valid bits; reset wins over flush, flush wins over normal flow.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else if (flush) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      if (s1_adv) s1_v_q <= accept;
      if (s2_adv) s2_v_q <= s1_v_q;
    end
  end

  // Stage 1 rows load only on an accepted transaction.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
    end else if (accept) begin
      s1_sum_q   <= s1_sum_d;
      s1_carry_q <= s1_carry_d;
    end
  end

  // Result loads only when stage 2 advances with valid stage 1 data; flush leaves it.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      result_q <= '0;
    end else if (!flush && s2_adv && s1_v_q) begin
      result_q <= result_d;
    end
  end

  assign out_valid = s2_v_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Scoreboard bench for mul_pipe_param at WIDTH=32 (directed + random),
// WIDTH=8 (exhaustive, signed and unsigned instances) and WIDTH=64 (random).
`timescale 1ns/1ps
module tb_mul_pipe_param;

  typedef struct {
    logic [127:0] exp;
    int           stamp;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- WIDTH=32 ----------------
  logic        resetn, flush, in_valid, s, out_ready;
  logic [31:0] x, y;
  logic        in_ready, out_valid;
  logic [63:0] result;

  mul_pipe_param #(.WIDTH(32)) dut (
    .mul_clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .y(y), .is_signed(s), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  // ---------------- WIDTH=8 ----------------
  logic        r8, v8;
  logic [7:0]  x8, y8;
  logic        rdy8s, ov8s, rdy8u, ov8u;
  logic [15:0] res8s, res8u;

  mul_pipe_param #(.WIDTH(8)) dut8s (
    .mul_clk(clk), .resetn(r8), .flush(1'b0), .in_valid(v8), .in_ready(rdy8s),
    .x(x8), .y(y8), .is_signed(1'b1), .out_valid(ov8s), .out_ready(1'b1),
    .result(res8s)
  );

  mul_pipe_param #(.WIDTH(8)) dut8u (
    .mul_clk(clk), .resetn(r8), .flush(1'b0), .in_valid(v8), .in_ready(rdy8u),
    .x(x8), .y(y8), .is_signed(1'b0), .out_valid(ov8u), .out_ready(1'b1),
    .result(res8u)
  );

  // ---------------- WIDTH=64 ----------------
  logic         r64, v64, s64;
  logic [63:0]  x64, y64;
  logic         rdy64, ov64;
  logic [127:0] res64;

  mul_pipe_param #(.WIDTH(64)) dut64 (
    .mul_clk(clk), .resetn(r64), .flush(1'b0), .in_valid(v64), .in_ready(rdy64),
    .x(x64), .y(y64), .is_signed(s64), .out_valid(ov64), .out_ready(1'b1),
    .result(res64)
  );

  // Reference: extend each operand to 128 bits per signedness, multiply, keep 2*w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic sgn, input int w);
    logic [127:0] wmask, pmask, ea, eb;
    wmask = (128'd1 << w) - 128'd1;
    pmask = (w == 64) ? '1 : ((128'd1 << (2*w)) - 128'd1);
    ea = {64'd0, a} & wmask;
    eb = {64'd0, b} & wmask;
    if (sgn && a[w-1]) ea = ea | ~wmask;
    if (sgn && b[w-1]) eb = eb | ~wmask;
    return (ea * eb) & pmask;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  item_t q32[$], q8s[$], q8u[$], q64[$];
  item_t it32, it8s, it8u, it64;
  int acc32 = 0, acc8s = 0, acc8u = 0, acc64 = 0;
  bit done8 = 0, done64 = 0;

  // Recorders: push the expected product when an acceptance will happen at the next edge.
  always @(negedge clk) begin
    if (!resetn || flush) q32.delete();
    else if (in_valid && in_ready) begin
      q32.push_back('{exp: ref_mul({32'd0, x}, {32'd0, y}, s, 32), stamp: cyc});
      acc32++;
    end
  end

  always @(negedge clk) begin
    if (r8 && v8 && rdy8s) begin
      q8s.push_back('{exp: ref_mul({56'd0, x8}, {56'd0, y8}, 1'b1, 8), stamp: cyc});
      acc8s++;
    end
    if (r8 && v8 && rdy8u) begin
      q8u.push_back('{exp: ref_mul({56'd0, x8}, {56'd0, y8}, 1'b0, 8), stamp: cyc});
      acc8u++;
    end
  end

  always @(negedge clk) begin
    if (r64 && v64 && rdy64) begin
      q64.push_back('{exp: ref_mul(x64, y64, s64, 64), stamp: cyc});
      acc64++;
    end
  end

  // Monitors: pop and compare on each delivery.
  always @(negedge clk) begin
    if (resetn && !flush && out_valid && out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL w32_unexpected: got output %0h expected no output", result);
      end else begin
        it32 = q32.pop_front();
        chk("w32_result", {64'd0, result}, it32.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (r8 && ov8s) begin
      if (q8s.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8s_unexpected: got output %0h expected no output", res8s);
      end else begin
        it8s = q8s.pop_front();
        chk("w8s_result", {112'd0, res8s}, it8s.exp);
        chk("w8s_latency", 128'(cyc - it8s.stamp), 128'd2);
      end
    end
    if (r8 && ov8u) begin
      if (q8u.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8u_unexpected: got output %0h expected no output", res8u);
      end else begin
        it8u = q8u.pop_front();
        chk("w8u_result", {112'd0, res8u}, it8u.exp);
        chk("w8u_latency", 128'(cyc - it8u.stamp), 128'd2);
      end
    end
  end

  always @(negedge clk) begin
    if (r64 && ov64) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL w64_unexpected: got output %0h expected no output", res64);
      end else begin
        it64 = q64.pop_front();
        chk("w64_result", res64, it64.exp);
        chk("w64_latency", 128'(cyc - it64.stamp), 128'd2);
      end
    end
  end

  // WIDTH=8 exhaustive driver (both instances share operands).
  initial begin : w8_drive
    r8 = 1'b0; v8 = 1'b0; x8 = '0; y8 = '0;
    repeat (2) @(posedge clk);
    #1;
    r8 = 1'b1;
    v8 = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      x8 = i[7:0];
      y8 = i[15:8];
      @(posedge clk); #1;
    end
    v8 = 1'b0;
    repeat (4) @(posedge clk);
    done8 = 1'b1;
  end

  // WIDTH=64 random driver.
  initial begin : w64_drive
    r64 = 1'b0; v64 = 1'b0; s64 = 1'b0; x64 = '0; y64 = '0;
    repeat (2) @(posedge clk);
    #1;
    r64 = 1'b1;
    v64 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x64 = (i == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      y64 = (i == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      s64 = (i < 2) ? i[0] : 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    v64 = 1'b0;
    repeat (4) @(posedge clk);
    done64 = 1'b1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sg);
    in_valid = v; x = a; y = b; s = sg;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(7, 0))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  int start;

  initial begin : main
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'd3, 32'd5, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_result", {64'd0, result}, 128'd0);
    step();

    // Corner products and latency; first op is accepted on the first edge out of reset.
    resetn = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step();
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    @(negedge clk);
    chk("lat_one_edge", {127'd0, out_valid}, 128'd0);
    step();
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    @(negedge clk);
    chk("lat_two_edges", {127'd0, out_valid}, 128'd1);
    chk("corner_m1_m1", {64'd0, result}, 128'h0000_0000_0000_0001);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("corner_min_min", {64'd0, result}, 128'h4000_0000_0000_0000);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("corner_min_one", {64'd0, result}, 128'hFFFF_FFFF_8000_0000);
    step();
    @(negedge clk);
    chk("corner_unsigned_max", {64'd0, result}, 128'hFFFF_FFFE_0000_0001);
    repeat (2) step();

    // Backpressure: A and B fill the pipe, C waits.
    out_ready = 1'b0;
    drive(1'b1, 32'd3, 32'd5, 1'b1);
    step();
    drive(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    step();
    drive(1'b1, 32'd0, 32'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_result_hold", {64'd0, result}, 128'd15);
      step();
    end
    out_ready = 1'b1;
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("bp_second", {64'd0, result}, 128'hFFFF_FFFF_FFFF_FFF2);
    step();
    @(negedge clk);
    chk("bp_third", {64'd0, result}, 128'd0);
    repeat (2) step();

    // Flush with two ops in flight; the op presented during flush must be ignored.
    out_ready = 1'b0;
    drive(1'b1, 32'd11, 32'd13, 1'b0);
    step();
    drive(1'b1, 32'd17, 32'd19, 1'b0);
    step();
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    flush = 1'b0;
    drive(1'b1, 32'd21, 32'd2, 1'b0);
    @(negedge clk);
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_result_kept", {64'd0, result}, 128'd143);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("post_flush_lat1", {127'd0, out_valid}, 128'd0);
    step();
    @(negedge clk);
    chk("post_flush_lat2", {127'd0, out_valid}, 128'd1);
    chk("post_flush_result", {64'd0, result}, 128'd42);
    repeat (2) step();

    // Reset mid-stream, asserted together with flush.
    out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd200, 1'b0);
    step();
    drive(1'b1, 32'd300, 32'd400, 1'b0);
    step();
    resetn = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    resetn = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_result", {64'd0, result}, 128'd0);
    repeat (5) step();
    @(negedge clk);
    chk("midrst_no_stale", {127'd0, out_valid}, 128'd0);
    step();

    // Random streaming with random valid and ready.
    start = acc32;
    for (int n = 0; n < 20000 && acc32 < start + 1000; n++) begin
      drive(1'($urandom_range(3, 0) != 0), pick32(), pick32(), 1'($urandom_range(1, 0)));
      out_ready = 1'($urandom_range(3, 0) != 0);
      step();
    end
    chk("stream_accepted", 128'(acc32 - start), 128'd1000);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q32.size() != 0; n++) step();
    chk("w32_drain", 128'(q32.size()), 128'd0);

    for (int n = 0; n < 80000 && !(done8 && done64); n++) step();
    chk("w8s_count", 128'(acc8s), 128'd65536);
    chk("w8u_count", 128'(acc8u), 128'd65536);
    chk("w64_count", 128'(acc64), 128'd300);
    chk("w8s_drain", 128'(q8s.size()), 128'd0);
    chk("w8u_drain", 128'(q8u.size()), 128'd0);
    chk("w64_drain", 128'(q64.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
